pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator, successor to the plain load-enabled PC register. Holds the fetch address, advances sequentially on an instruction-memory handshake, applies branch/jump redirects with a pending buffer when the pipeline is held, and sequences a programmable boot delay after reset. It sits between the branch unit / control path and the instruction-memory port at the front of the pipeline.

## Interface
- XLEN, 32, address width
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset (XLEN bits, word-aligned)
- INSTR_BYTES, 4, sequential increment (power of two, ≥2)
- BOOT_DELAY, 2, cycles after reset release before the first fetch is offered (0 allowed)

Ports:
- clk  in  1  clock, rising edge
- areset  in  1  asynchronous reset, active-low
- hold  in  1  pipeline stall; freezes PC and defers redirects
- fetchReady  in  1  instruction memory accepts current pc
- redirect  in  1  taken branch/jump this cycle
- redirectPc  in  XLEN  redirect target
- fetchValid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch address (registered)
- pcPlus  out  XLEN  pc + INSTR_BYTES (combinational)

## Operation
- Reset (areset=0, any time, async): pc=RESET_VECTOR, fetchValid=0, state BOOT, boot counter=0, pending flag/address cleared.
- States: BOOT, RUN, PEND.
- BOOT: counter increments each cycle; when counter==BOOT_DELAY, next state RUN. BOOT_DELAY=0 -> RUN on first clock after release. A redirect in BOOT is captured into pending; on BOOT->RUN, pc loads pending address.
- RUN: fetchValid=1. Priority per cycle: redirect > advance.
  - redirect=1, hold=0: pc<=aligned(redirectPc), fetchReady ignored (current request abandoned).
  - redirect=1, hold=1: capture aligned(redirectPc) in pending, go PEND.
  - redirect=0, hold=0, fetchReady=1: pc<=pc+INSTR_BYTES (wraps mod 2^XLEN).
  - otherwise pc unchanged.
- PEND: fetchValid=0. A newer redirect overwrites pending (last wins). When hold=0: pc<=pending (or newer redirectPc if redirect=1 that cycle), pending cleared, go RUN.
- aligned(x): low log2(INSTR_BYTES) bits forced to 0 (see Configuration).
- pc arithmetic strictly XLEN-bit; carry out discarded.

## Timing
- Redirect at edge N -> pc=target, fetchValid=1 from cycle N+1.
- Sequential advance: handshake (fetchValid&fetchReady&!hold) at edge N -> pc+INSTR_BYTES at N+1.
- hold deasserted at edge N in PEND -> pc=pending, fetchValid=1 at N+1.
- First fetchValid=1 exactly BOOT_DELAY+1 rising edges after areset release.
- pcPlus tracks pc with zero latency.

## Configuration
- PC_TRAP_EN defined: misaligned redirect target (low bits ≠0) is not masked; adds inputs trap (1) and trapVector (XLEN) and output misaligned (1). Misaligned redirect or trap=1 loads trapVector with top priority (trap > redirect > advance), deferred through PEND like a redirect if hold=1; misaligned pulses 1 cycle on the edge the bad target is seen. misaligned resets to 0.
- PC_TRAP_EN undefined: ports absent; redirect targets silently aligned.

## Structure
- Package pc_pkg: state enum (BOOT, RUN, PEND), INSTR_BYTES default, alignment-mask function, reset-vector default.
- Single module; no sub-module (boot counter and pending register are inline).

## Test plan
- Reset, BOOT_DELAY=2, fetchReady=1: fetchValid rises on 3rd edge after release; pc 0x0,0x4,0x8 on successive cycles.
- RUN, fetchReady=0 for 3 cycles: pc stays 0x8, fetchValid=1; then advances to 0xC.
- redirect=1, redirectPc=0x100, hold=0: next cycle pc=0x100; redirectPc=0x0FFF_FFFE (trap macro off): pc=0x0FFF_FFFC.
- hold=1, redirect 0x200 then 0x300 in successive cycles, hold drops: fetchValid=0 during hold, then pc=0x300 next cycle.
- pc=0xFFFF_FFFC, fetchReady=1: pc wraps to 0x0.
- PC_TRAP_EN, trapVector=0x80, redirectPc=0x102: misaligned pulse 1 cycle, pc=0x80; areset low mid-PEND: pc=RESET_VECTOR immediately, pending discarded.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the fetch program-counter generator.
//   state_e          : BOOT / RUN / PEND sequencing states
//   DEF_*            : default parameter values for pc_gen
//   low_mask()       : mask of the address bits that must be zero for alignment
package pc_pkg;

  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_INSTR_BYTES  = 4;
  localparam int unsigned DEF_BOOT_DELAY   = 2;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  // Low-order address bits that are zero in an aligned pc (INSTR_BYTES is a power of two).
  function automatic int unsigned low_mask(input int unsigned instr_bytes);
    return instr_bytes - 1;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
//   Holds the fetch address, advances on an instruction-memory handshake,
//   applies redirects (buffered while the pipeline is held) and waits a
//   programmable boot delay after reset before offering the first fetch.
// Ports:
//   clk         in   rising-edge clock
//   areset      in   asynchronous active-low reset
//   hold        in   pipeline stall; freezes pc and defers redirects
//   fetchReady  in   instruction memory accepts current pc
//   redirect    in   taken branch/jump this cycle
//   redirectPc  in   redirect target
//   trap        in   (PC_TRAP_EN only) force load of trapVector
//   trapVector  in   (PC_TRAP_EN only) trap target
//   misaligned  out  (PC_TRAP_EN only) one-cycle pulse on misaligned redirect
//   fetchValid  out  pc is a valid fetch request (registered)
//   pc          out  current fetch address (registered)
//   pcPlus      out  pc + INSTR_BYTES (combinational)
// Optional feature macro: PC_TRAP_EN
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned     INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int unsigned     BOOT_DELAY   = DEF_BOOT_DELAY
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            hold,
  input  logic            fetchReady,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirectPc,
`ifdef PC_TRAP_EN
  input  logic            trap,
  input  logic [XLEN-1:0] trapVector,
  output logic            misaligned,
`endif
  output logic            fetchValid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus
);

  localparam int unsigned     CNT_W    = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(low_mask(INSTR_BYTES));
  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

  state_e            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [XLEN-1:0]   pc_d;
  logic              pend_v, pend_v_d;
  logic [XLEN-1:0]   pend_addr, pend_addr_d;
  logic              valid_d;

  // Redirect-class event for this cycle and the address it targets.
  logic              evt_v;
  logic [XLEN-1:0]   evt_tgt;

`ifdef PC_TRAP_EN
  logic bad_c;
  logic mis_q;

  always_comb begin
    bad_c   = redirect && ((redirectPc & LOW_MASK) != '0);
    evt_v   = trap || redirect;
    evt_tgt = (trap || bad_c) ? trapVector : redirectPc;
  end

  // Misaligned pulse marks the edge the bad target was observed.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) mis_q <= 1'b0;
    else         mis_q <= bad_c;
  end

  assign misaligned = mis_q;
`else
  always_comb begin
    evt_v   = redirect;
    evt_tgt = redirectPc & ~LOW_MASK;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state      <= ST_BOOT;
      cnt        <= '0;
      pc         <= RESET_VECTOR;
      pend_v     <= 1'b0;
      pend_addr  <= '0;
      fetchValid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pc         <= pc_d;
      pend_v     <= pend_v_d;
      pend_addr  <= pend_addr_d;
      fetchValid <= valid_d;
    end
  end

  // Next-state and next-pc selection.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pc_d        = pc;
    pend_v_d    = pend_v;
    pend_addr_d = pend_addr;

    unique case (state)
      ST_BOOT: begin
        if (evt_v) begin
          pend_v_d    = 1'b1;
          pend_addr_d = evt_tgt;
        end
        if (cnt == CNT_W'(BOOT_DELAY)) begin
          // Newest redirect wins over one buffered earlier in boot.
          state_d  = ST_RUN;
          pend_v_d = 1'b0;
          if (evt_v)       pc_d = evt_tgt;
          else if (pend_v) pc_d = pend_addr;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (evt_v) begin
          if (hold) begin
            pend_v_d    = 1'b1;
            pend_addr_d = evt_tgt;
            state_d     = ST_PEND;
          end else begin
            pc_d = evt_tgt;
          end
        end else if (!hold && fetchReady) begin
          pc_d = pc + STEP;
        end
      end

      ST_PEND: begin
        if (evt_v) pend_addr_d = evt_tgt;
        if (!hold) begin
          pc_d     = evt_v ? evt_tgt : pend_addr;
          pend_v_d = 1'b0;
          state_d  = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    valid_d = (state_d == ST_RUN);
  end

  assign pcPlus = pc + STEP;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (default parameters).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic        hold;
  logic        fetchReady;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        fetchValid;
  logic [31:0] pc;
  logic [31:0] pcPlus;
`ifdef PC_TRAP_EN
  logic        trap;
  logic [31:0] trapVector;
  logic        misaligned;
`endif

  int errors = 0;
  int checks = 0;

  pc_gen dut (
    .clk        (clk),
    .areset     (areset),
    .hold       (hold),
    .fetchReady (fetchReady),
    .redirect   (redirect),
    .redirectPc (redirectPc),
`ifdef PC_TRAP_EN
    .trap       (trap),
    .trapVector (trapVector),
    .misaligned (misaligned),
`endif
    .fetchValid (fetchValid),
    .pc         (pc),
    .pcPlus     (pcPlus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b0; hold = 1'b0; fetchReady = 1'b1; redirect = 1'b0; redirectPc = '0;
`ifdef PC_TRAP_EN
    trap = 1'b0; trapVector = 32'h80;
`endif
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", fetchValid); end
    checks++; if (pcPlus !== 32'h4) begin errors++; $display("FAIL reset_pcplus: got %h expected %h", pcPlus, 32'h4); end
    areset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL boot_valid_edge%0d: got %b expected 0", i, fetchValid); end
    end
    step();
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL boot_valid_edge3: got %b expected 1", fetchValid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL first_pc: got %h expected %h", pc, 32'h0); end
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h expected %h", pc, 32'h4); end
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h expected %h", pc, 32'h8); end
  endtask

  task automatic test_stall();
    fetchReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc%0d: got %h expected %h", i, pc, 32'h8); end
      checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b expected 1", i, fetchValid); end
    end
    fetchReady = 1'b1;
    step();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_release: got %h expected %h", pc, 32'hC); end
    fetchReady = 1'b0;
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirectPc = 32'h100; fetchReady = 1'b1;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b expected 1", fetchValid); end
    redirectPc = 32'h0FFF_FFFE; fetchReady = 1'b0;
    step();
    checks++; if (pc !== 32'h0FFF_FFFC) begin errors++; $display("FAIL redir_align: got %h expected %h", pc, 32'h0FFF_FFFC); end
    checks++; if (pcPlus !== 32'h1000_0000) begin errors++; $display("FAIL redir_pcplus: got %h expected %h", pcPlus, 32'h1000_0000); end
    redirect = 1'b0;
  endtask

  task automatic test_hold_pend();
    hold = 1'b1; redirect = 1'b1; redirectPc = 32'h200;
    step();
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL pend_valid1: got %b expected 0", fetchValid); end
    checks++; if (pc !== 32'h0FFF_FFFC) begin errors++; $display("FAIL pend_pc_frozen: got %h expected %h", pc, 32'h0FFF_FFFC); end
    redirectPc = 32'h300;
    step();
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL pend_valid2: got %b expected 0", fetchValid); end
    redirect = 1'b0;
    step();
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL pend_valid3: got %b expected 0", fetchValid); end
    hold = 1'b0;
    step();
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL pend_last_wins: got %h expected %h", pc, 32'h300); end
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL pend_resume_valid: got %b expected 1", fetchValid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
    step();
    checks++; if (pcPlus !== 32'h0) begin errors++; $display("FAIL wrap_pcplus: got %h expected %h", pcPlus, 32'h0); end
    redirect = 1'b0; fetchReady = 1'b1;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
    fetchReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Redirect beats a simultaneous handshake.
    redirect = 1'b1; redirectPc = 32'h44; fetchReady = 1'b1;
    step();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL b2b_prio: got %h expected %h", pc, 32'h44); end
    // New redirect arriving on the cycle hold drops replaces the buffered one.
    hold = 1'b1; redirectPc = 32'h400;
    step();
    hold = 1'b0; redirectPc = 32'h500;
    step();
    checks++; if (pc !== 32'h500) begin errors++; $display("FAIL b2b_pend_newer: got %h expected %h", pc, 32'h500); end
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", fetchValid); end
    redirect = 1'b0;
    step();
    checks++; if (pc !== 32'h504) begin errors++; $display("FAIL b2b_advance: got %h expected %h", pc, 32'h504); end
    fetchReady = 1'b0;
  endtask

  task automatic test_reset_mid_pend();
    hold = 1'b1; redirect = 1'b1; redirectPc = 32'h600;
    step();
    redirect = 1'b0;
    #2 areset = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", fetchValid); end
    #2 areset = 1'b1; hold = 1'b0;
    step(); step(); step();
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL rst_pend_valid: got %b expected 1", fetchValid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pend_discard: got %h expected %h", pc, 32'h0); end
  endtask

  task automatic test_boot_redirect();
    areset = 1'b0;
    step();
    areset = 1'b1; redirect = 1'b1; redirectPc = 32'h700;
    step();
    redirect = 1'b0;
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL bootredir_valid: got %b expected 0", fetchValid); end
    step(); step();
    checks++; if (pc !== 32'h700) begin errors++; $display("FAIL bootredir_pc: got %h expected %h", pc, 32'h700); end
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL bootredir_run: got %b expected 1", fetchValid); end
  endtask

`ifdef PC_TRAP_EN
  task automatic test_trap();
    trapVector = 32'h80; redirect = 1'b1; redirectPc = 32'h102;
    step();
    redirect = 1'b0;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL trap_pulse: got %b expected 1", misaligned); end
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL trap_pc: got %h expected %h", pc, 32'h80); end
    step();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL trap_pulse_end: got %b expected 0", misaligned); end
  endtask
`endif

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_hold_pend();
    test_wrap();
    test_back_to_back();
    test_reset_mid_pend();
    test_boot_redirect();
`ifdef PC_TRAP_EN
    test_trap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
